// File: rtl/param_reg_file.sv
// Parametrised register file: two combinational read ports, one write port, per-entry pending scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module param_reg_file #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] readAddrA,
    output logic [WIDTH-1:0]  readDataA,
    output logic              readPendA,
    input  logic [ADDR_W-1:0] readAddrB,
    output logic [WIDTH-1:0]  readDataB,
    output logic              readPendB,
    input  logic              write,
    input  logic [ADDR_W-1:0] writeAddr,
    input  logic [WIDTH-1:0]  dataIn,
    input  logic              reserve,
    input  logic [ADDR_W-1:0] reserveAddr,
    output logic [ADDR_W:0]   pendCount
);

    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] pend_q, pend_d;
    logic [ADDR_W:0]  pendCount_q, pendCount_d;
    logic             wr_eff, rs_eff, inc, dec;

    assign wr_eff = write   && !(ZERO_EN && (writeAddr   == '0));
    assign rs_eff = reserve && !(ZERO_EN && (reserveAddr == '0));

    // Reserve is applied after the write clear so a same-address collision leaves the entry pending.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (wr_eff) begin
            mem_d[writeAddr]  = dataIn;
            pend_d[writeAddr] = 1'b0;
        end
        if (rs_eff) begin
            pend_d[reserveAddr] = 1'b1;
        end
    end

    always_comb begin
        inc = rs_eff && !pend_q[reserveAddr];
        dec = wr_eff && pend_q[writeAddr] && !(rs_eff && (reserveAddr == writeAddr));
        pendCount_d = pendCount_q;
        if (inc && !dec) begin
            pendCount_d = pendCount_q + (ADDR_W+1)'(1);
        end else if (dec && !inc) begin
            pendCount_d = pendCount_q - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q       <= '{default: '0};
            pend_q      <= '0;
            pendCount_q <= '0;
        end else begin
            mem_q       <= mem_d;
            pend_q      <= pend_d;
            pendCount_q <= pendCount_d;
        end
    end

    assign pendCount = pendCount_q;

    always_comb begin
        readDataA = mem_q[readAddrA];
        readPendA = pend_q[readAddrA];
`ifdef REGFILE_BYPASS_EN
        if (wr_eff && (readAddrA == writeAddr)) begin
            readDataA = dataIn;
            readPendA = rs_eff && (reserveAddr == writeAddr);
        end
`endif
        if (ZERO_EN && (readAddrA == '0)) begin
            readDataA = '0;
            readPendA = 1'b0;
        end
    end

    always_comb begin
        readDataB = mem_q[readAddrB];
        readPendB = pend_q[readAddrB];
`ifdef REGFILE_BYPASS_EN
        if (wr_eff && (readAddrB == writeAddr)) begin
            readDataB = dataIn;
            readPendB = rs_eff && (reserveAddr == writeAddr);
        end
`endif
        if (ZERO_EN && (readAddrB == '0)) begin
            readDataB = '0;
            readPendB = 1'b0;
        end
    end

endmodule
